// File: rtl/blink_rate_selector.sv
// blink_rate_selector: conditions the board push-button and steps a four-entry
// divisor table for clock_divider. Define BLINK_RATE_DOWN_EN to add a down button.

module blink_btn_cond #(
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic fall
);

  localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          btn_db_q, btn_db_d;
  logic          btn_db_dly_q, btn_db_dly_d;
  logic [CW-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]    settle_q, settle_d;
  logic          armed_q, armed_d;

  always_comb begin
    sync1_d      = btn_n;
    sync2_d      = sync1_q;
    btn_db_d     = btn_db_q;
    db_cnt_d     = db_cnt_q;
    btn_db_dly_d = btn_db_q;
    settle_d     = settle_q;
    armed_d      = armed_q;

    if (sync2_q == btn_db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == CNT_LAST) begin
      btn_db_d = sync2_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + CW'(1);
    end

    // The synchronizer outputs are only trustworthy two edges after reset; a
    // button must be seen released after that before any press may count, so a
    // button held through reset does not produce a step.
    if (settle_q != 2'd2) begin
      settle_d = settle_q + 2'd1;
    end else if (sync2_q) begin
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      btn_db_q     <= 1'b1;
      btn_db_dly_q <= 1'b1;
      db_cnt_q     <= '0;
      settle_q     <= 2'd0;
      armed_q      <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      btn_db_q     <= btn_db_d;
      btn_db_dly_q <= btn_db_dly_d;
      db_cnt_q     <= db_cnt_d;
      settle_q     <= settle_d;
      armed_q      <= armed_d;
    end
  end

  assign fall = armed_q & btn_db_dly_q & ~btn_db_q;

endmodule

module blink_rate_selector #(
  parameter int          DEBOUNCE_CYCLES = 120000,
  parameter logic [23:0] RATE0           = 24'd6000000,
  parameter logic [23:0] RATE1           = 24'd3000000,
  parameter logic [23:0] RATE2           = 24'd1500000,
  parameter logic [23:0] RATE3           = 24'd750000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_n,
`ifdef BLINK_RATE_DOWN_EN
  input  logic        btn_down_n,
`endif
  output logic [23:0] div,
  output logic [1:0]  rate_idx,
  output logic        changed
);

  logic        up_fall;
  logic        dn_fall;
  logic        press_q, press_d;
  logic [1:0]  rate_idx_q, rate_idx_d;
  logic [23:0] div_q, div_d;
  logic        changed_q, changed_d;

  blink_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_n),
    .fall  (up_fall)
  );

`ifdef BLINK_RATE_DOWN_EN
  blink_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_down_n),
    .fall  (dn_fall)
  );
`else
  assign dn_fall = 1'b0;
`endif

  function automatic logic [23:0] rate_lut(input logic [1:0] idx);
    logic [23:0] r;
    case (idx)
      2'd0:    r = RATE0;
      2'd1:    r = RATE1;
      2'd2:    r = RATE2;
      default: r = RATE3;
    endcase
    return r;
  endfunction

  always_comb begin
    press_d    = 1'b0;
    rate_idx_d = rate_idx_q;
    // A step on the cycle right after another would give a back-to-back
    // changed strobe; only the two-button case can get that close, and it is dropped.
    if (!press_q) begin
      if (up_fall && !dn_fall) begin
        press_d    = 1'b1;
        rate_idx_d = rate_idx_q + 2'd1;
      end else if (dn_fall && !up_fall) begin
        press_d    = 1'b1;
        rate_idx_d = rate_idx_q - 2'd1;
      end
    end
    div_d     = rate_lut(rate_idx_q);
    changed_d = press_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_q    <= 1'b0;
      rate_idx_q <= 2'd0;
      div_q      <= RATE0;
      changed_q  <= 1'b0;
    end else begin
      press_q    <= press_d;
      rate_idx_q <= rate_idx_d;
      div_q      <= div_d;
      changed_q  <= changed_d;
    end
  end

  assign div      = div_q;
  assign rate_idx = rate_idx_q;
  assign changed  = changed_q;

endmodule

// File: tb/tb_blink_rate_selector.sv
// Scoreboard bench for blink_rate_selector with DEBOUNCE_CYCLES=4; define
// BLINK_RATE_DOWN_EN on both bench and design to exercise the down button.

module tb_blink_rate_selector;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        btn_n = 1'b1;
`ifdef BLINK_RATE_DOWN_EN
  logic        btn_down_n = 1'b1;
`endif
  logic [23:0] div;
  logic [1:0]  rate_idx;
  logic        changed;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_chg = -1;
  bit chg_prev = 1'b0;

  typedef struct {
    int         cyc;
    logic [1:0] idx;
  } exp_t;
  exp_t exp_q[$];

  // Behavioural button model per button: two-sample delay, run-length debounce, arm.
  bit         m1[2], m2[2], mdb[2], marmed[2];
  int         mrun[2];
  logic [1:0] m_idx;

  always #5 clk = ~clk;

  blink_rate_selector #(.DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_n      (btn_n),
`ifdef BLINK_RATE_DOWN_EN
    .btn_down_n (btn_down_n),
`endif
    .div        (div),
    .rate_idx   (rate_idx),
    .changed    (changed)
  );

  function automatic logic [23:0] rate_of(input logic [1:0] i);
    case (i)
      2'd0:    return 24'd6000000;
      2'd1:    return 24'd3000000;
      2'd2:    return 24'd1500000;
      default: return 24'd750000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_edge(input int b, input bit raw, output bit fell);
    bit in_v;
    in_v = m2[b];
    fell = 1'b0;
    if (in_v != mdb[b]) begin
      mrun[b]++;
      if (mrun[b] == D) begin
        mdb[b]  = in_v;
        mrun[b] = 0;
        fell    = !in_v && marmed[b];
      end
    end else begin
      mrun[b] = 0;
    end
    m2[b] = m1[b];
    m1[b] = raw;
    if (raw) marmed[b] = 1'b1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        m1[b] = 1'b1; m2[b] = 1'b1; mdb[b] = 1'b1; marmed[b] = 1'b0; mrun[b] = 0;
      end
      m_idx = 2'd0;
      exp_q.delete();
    end else begin
      bit   fu, fd;
      exp_t e;
      cyc++;
      model_edge(0, btn_n, fu);
      fd = 1'b0;
`ifdef BLINK_RATE_DOWN_EN
      model_edge(1, btn_down_n, fd);
`endif
      if (fu != fd) begin
        m_idx = fu ? m_idx + 2'd1 : m_idx - 2'd1;
        e.cyc = cyc + 2;
        e.idx = m_idx;
        exp_q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (changed) begin
        exp_t e;
        last_chg = cyc;
        checks++;
        if (chg_prev) begin
          errors++;
          $display("FAIL changed_twice: changed high on consecutive cycles at cycle %0d", cyc);
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_changed: changed=1 at cycle %0d with no step expected", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("changed_cycle", cyc, e.cyc);
          chk("changed_idx", {30'd0, rate_idx}, {30'd0, e.idx});
          chk("changed_div", {8'd0, div}, {8'd0, rate_of(e.idx)});
        end
      end
      chg_prev = changed;
    end else begin
      chg_prev = 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit up, input bit dn, input int low, input int high);
    @(negedge clk);
    if (up) btn_n = 1'b0;
`ifdef BLINK_RATE_DOWN_EN
    if (dn) btn_down_n = 1'b0;
`endif
    repeat (low) @(negedge clk);
    btn_n = 1'b1;
`ifdef BLINK_RATE_DOWN_EN
    btn_down_n = 1'b1;
`endif
    repeat (high) @(negedge clk);
  endtask

  task automatic check_state(input string name);
    chk({name, "_idx"}, {30'd0, rate_idx}, {30'd0, m_idx});
    chk({name, "_div"}, {8'd0, div}, {8'd0, rate_of(m_idx)});
    chk({name, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_div", {8'd0, div}, 32'd6000000);
    chk("rst_idx", {30'd0, rate_idx}, 32'd0);
    chk("rst_changed", {31'd0, changed}, 32'd0);
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    int step_before;
    #1 rst_n = 1'b0;
    #1;
    chk("init_div", {8'd0, div}, 32'd6000000);
    chk("init_idx", {30'd0, rate_idx}, 32'd0);
    chk("init_changed", {31'd0, changed}, 32'd0);
    idle(3);
    rst_n = 1'b1;
    idle(6);
    check_state("after_reset");

    // Single clean press: one strobe exactly 8 edges after btn_n falls.
    @(negedge clk);
    c0 = cyc;
    last_chg = -1;
    btn_n = 1'b0;
    idle(20);
    btn_n = 1'b1;
    idle(12);
    chk("press_latency", last_chg, c0 + 8);
    chk("press1_div", {8'd0, div}, 32'd3000000);
    chk("press1_idx", {30'd0, rate_idx}, 32'd1);
    check_state("press1");

    press(1'b1, 1'b0, 8, 8);
    chk("press2_div", {8'd0, div}, 32'd1500000);
    press(1'b1, 1'b0, 8, 8);
    chk("press3_div", {8'd0, div}, 32'd750000);
    chk("press3_idx", {30'd0, rate_idx}, 32'd3);
    press(1'b1, 1'b0, 8, 8);
    chk("wrap_div", {8'd0, div}, 32'd6000000);
    chk("wrap_idx", {30'd0, rate_idx}, 32'd0);

    // Short glitch must not step.
    press(1'b1, 1'b0, 3, 8);
    chk("glitch_div", {8'd0, div}, 32'd6000000);
    check_state("glitch");

    // Bounces then a stable low: exactly one step.
    repeat (3) press(1'b1, 1'b0, 3, 2);
    press(1'b1, 1'b0, 10, 8);
    chk("bounce_idx", {30'd0, rate_idx}, 32'd1);
    check_state("bounce");

    // Reset mid-debounce with the button held through reset release.
    @(negedge clk);
    btn_n = 1'b0;
    idle(3);
    do_reset();
    idle(14);
    chk("held_idx", {30'd0, rate_idx}, 32'd0);
    check_state("held");
    btn_n = 1'b1;
    idle(8);
    press(1'b1, 1'b0, 8, 8);
    chk("after_held_idx", {30'd0, rate_idx}, 32'd1);
    check_state("after_held");

    // Random presses and bounces against the model.
    for (int i = 0; i < 40; i++) begin
      bit use_dn;
      use_dn = 1'b0;
`ifdef BLINK_RATE_DOWN_EN
      use_dn = $urandom_range(0, 1) == 1;
`endif
      press(!use_dn, use_dn, $urandom_range(1, 9), $urandom_range(1, 9));
    end
    idle(10);
    check_state("random");

`ifdef BLINK_RATE_DOWN_EN
    do_reset();
    idle(6);
    press(1'b0, 1'b1, 8, 8);
    chk("down_div", {8'd0, div}, 32'd750000);
    chk("down_idx", {30'd0, rate_idx}, 32'd3);
    step_before = last_chg;
    press(1'b1, 1'b1, 10, 10);
    chk("cancel_no_strobe", last_chg, step_before);
    chk("cancel_div", {8'd0, div}, 32'd750000);
    check_state("cancel");
`else
    step_before = last_chg;
    idle(4);
    chk("quiet_no_strobe", last_chg, step_before);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
